uart_rx: RTL and testbench

Serial UART receiver that converts an asynchronous 8N1 line, such as the PIO `uart_tx` program output on a `gpio_out` bit, back into bytes. The received bytes go out on a one-entry valid/ready holding register. It is used in the PIO simulation benches as the checker for transmit programs. It is also the fabric-side receive path in top-level designs where the PIO drives a serial line. The bit period is programmable at run time so it can match the PIO clock divider and the cycles-per-bit of the program.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_ff.sv | 24 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The half-bit helper sets where the start bit is sampled.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  function automatic logic [UART_DIV_W-1:0] half_bit_load(
    input logic [UART_DIV_W-1:0] bit_div
  );
    return (bit_div >> 1) - 16'd1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous input.
// All stages reset to 1 so an idle serial line reads as idle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with a run-time bit period
// and a single-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_e               state_q, state_d;
  logic [15:0]          bit_div_q, bit_div_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 fin_q, fin_d;
  logic                 rx_s;
  logic                 cnt_zero;
  logic                 good;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign cnt_zero = (cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_div_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_div_q <= bit_div_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      fin_q     <= fin_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_div_d = bit_div_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    ferr_d    = 1'b0;
    fin_d     = 1'b0;
    good      = 1'b0;

    if (state_q == ST_START || state_q == ST_DATA ||
        state_q == ST_STOP) begin
      cnt_d = cnt_q - 16'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          bit_div_d = div;
          cnt_d     = half_bit_load(div);
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            cnt_d   = bit_div_q - 16'd1;
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          sh_d              = sh_q >> 1;
          sh_d[DATA_BITS-1] = rx_s;
          cnt_d             = bit_div_q - 16'd1;
          idx_d             = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt_zero) begin
          fin_d = 1'b1;
          if (rx_s) begin
            good    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A completed byte wins over a same-cycle accept; a full, unaccepted
  // register keeps its old byte and flags the loss instead.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (good) begin
      if (valid_q && !ready) begin
        ovr_d = 1'b1;
      end else begin
        dout_d  = sh_q;
        valid_d = 1'b1;
      end
    end
  end

  assign dout        = dout_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != ST_IDLE) || fin_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are driven
// bit by bit and expected bytes/pulses are predicted from timing rules.
module tb_uart_rx;

  localparam int DB    = 8;
  localparam int SYNC  = 2;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    logic [7:0] b;
    int         t;
  } dexp_t;

  typedef struct {
    int kind;
    int t;
  } eexp_t;

  logic          clk;
  logic          reset;
  logic [15:0]   div;
  logic          rx;
  logic [DB-1:0] dout;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          framing_err;
  logic          overrun;

  int vectors;
  int miscompares;
  int cyc;

  dexp_t data_q[$];
  eexp_t evt_q[$];
  dexp_t de;
  eexp_t ee;

  uart_rx #(
    .DATA_BITS   (DB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .div         (div),
    .rx          (rx),
    .dout        (dout),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: output seen with nothing expected (cycle %0d)",
             name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) begin
        if (data_q.size() == 0) begin
          unexpected("valid");
        end else begin
          de = data_q.pop_front();
          check("dout", int'(dout), int'(de.b));
          if (de.t >= 0) check("valid_time", cyc, de.t);
        end
      end
      if (framing_err) begin
        if (evt_q.size() == 0) begin
          unexpected("framing_err");
        end else begin
          ee = evt_q.pop_front();
          check("ferr_kind", EV_FERR, ee.kind);
          check("ferr_time", cyc, ee.t);
        end
      end
      if (overrun) begin
        if (evt_q.size() == 0) begin
          unexpected("overrun");
        end else begin
          ee = evt_q.pop_front();
          check("ovr_kind", EV_OVR, ee.kind);
          check("ovr_time", cyc, ee.t);
        end
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 = byte expected, EV_OVR = overrun expected,
  // EV_FERR = framing error (stop held low for stop_low cycles).
  task automatic send_frame(input logic [7:0] b, input int d,
                            input int kind, input int stop_low,
                            input bit timed);
    int    n;
    int    t;
    dexp_t dx;
    eexp_t ex;
    @(posedge clk);
    #1;
    n   = cyc;
    div = d[15:0];
    rx  = 1'b0;
    t   = n + SYNC + d / 2 + (DB + 1) * d + 1;
    if (kind == 0) begin
      dx.b = b;
      dx.t = timed ? t : -1;
      data_q.push_back(dx);
    end else begin
      ex.kind = kind;
      ex.t    = t;
      evt_q.push_back(ex);
    end
    repeat (3) @(posedge clk);
    #1;
    div = 16'($urandom_range(4, 65535));
    repeat (d - 3) @(posedge clk);
    #1;
    for (int k = 0; k < DB; k++) begin
      rx = b[k];
      repeat (d) @(posedge clk);
      #1;
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low) @(posedge clk);
      #1;
      check("break_busy", int'(busy), 1);
    end
    rx = 1'b1;
    repeat (d) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int n;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    div   = 16'd16;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_ferr", int'(framing_err), 0);
    check("rst_ovr", int'(overrun), 0);
    idle(4);

    // single byte, exact latency
    send_frame(8'h30, 16, 0, 0, 1'b1);
    idle(5);

    // loopback-style burst 0x30..0x39, back to back
    for (int i = 0; i < 10; i++) begin
      send_frame(8'(8'h30 + i), 16, 0, 0, 1'b1);
    end
    idle(5);

    // false start
    @(posedge clk);
    #1;
    div = 16'd16;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx  = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("false_start_busy", int'(cnt >= 1 && cnt <= 8), 1);
    idle(3);

    // framing error, break, then recovery
    send_frame(8'h55, 16, EV_FERR, 40, 1'b1);
    check("break_released", int'(busy), 0);
    send_frame(8'hA5, 16, 0, 0, 1'b1);
    idle(5);

    // overrun with a stalled consumer
    ready = 1'b0;
    send_frame(8'h11, 16, 0, 0, 1'b0);
    send_frame(8'h22, 16, EV_OVR, 0, 1'b1);
    idle(3);
    check("ovr_dout", int'(dout), 8'h11);
    check("ovr_valid", int'(valid), 1);
    ready = 1'b1;
    idle(2);
    check("ovr_drain", int'(valid), 0);
    idle(3);

    // reset during data bit 3 of 0xFF
    @(posedge clk);
    #1;
    div = 16'd16;
    rx  = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      rx = 1'b1;
      repeat (16) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_ferr", int'(framing_err), 0);
    check("mid_rst_ovr", int'(overrun), 0);
    idle(16 * 6);
    send_frame(8'h42, 16, 0, 0, 1'b1);
    idle(5);

    // randomized frames and bit periods
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom), $urandom_range(4, 48), 0, 0, 1'b1);
      idle($urandom_range(0, 3));
    end

    n = 0;
    while ((data_q.size() != 0 || evt_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("data_q_drained", data_q.size(), 0);
    check("evt_q_drained", evt_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
